// File: rtl/resilient_rx_endpoint_pkg.sv
// rtl/resilient_rx_endpoint_pkg.sv - shared types and constants for the resilient receive endpoint
// Purpose: FSM state encoding and the stored token layout used by resilient_rx_endpoint.
// Ports: none (package).
package resilient_pkg;

    localparam int RX_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REPORT = 2'd1,
        RTZ    = 2'd2
    } state_e;

    // Flat encodings so the state register can stay a plain logic vector.
    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_REPORT = 2'(REPORT);
    localparam logic [1:0] ST_RTZ    = 2'(RTZ);

    typedef struct packed {
        logic            err;
        logic [RX_W-1:0] data;
    } rx_token_t;

endpackage

// File: rtl/resilient_rx_endpoint_if.sv
// rtl/resilient_rx_endpoint_if.sv - token, error-report and consumer signals of the receive endpoint
// Purpose: bundles the 2-phase token channel, the dual-rail error channel and the FIFO output.
// Ports (master = upstream/consumer side, slave = endpoint):
//   rreq, rdata, rpar, reack, out_ready : master -> slave
//   rack, err1, err0, out_valid, out_data, out_err : slave -> master
interface resilient_rx_endpoint_if #(
    parameter int W = 8
);
    logic         rreq;
    logic [W-1:0] rdata;
    logic         rpar;
    logic         rack;
    logic         err1;
    logic         err0;
    logic         reack;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_err;
    logic         out_ready;

    modport master (
        output rreq, rdata, rpar, reack, out_ready,
        input  rack, err1, err0, out_valid, out_data, out_err
    );

    modport slave (
        input  rreq, rdata, rpar, reack, out_ready,
        output rack, err1, err0, out_valid, out_data, out_err
    );

endinterface

// File: rtl/resilient_rx_endpoint_sync_ff.sv
// rtl/resilient_rx_endpoint_sync_ff.sv - multi-stage flop synchroniser for asynchronous handshake inputs
// Purpose: brings rreq / reack into the clk domain through STAGES flops, reset to 0.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/resilient_rx_endpoint.sv
// rtl/resilient_rx_endpoint.sv - receiving end of the resilient bundled-data channel
// Purpose: accepts 2-phase rreq/rack tokens with bundled data + even parity, reports each
//   token's parity status on the dual-rail err1/err0 channel (4-phase, acked by reack), and
//   buffers tokens in a DEPTH-entry FIFO for the clocked consumer.
// Ports: clk, rst (sync, active-high), bus (resilient_rx_endpoint_if.slave):
//   rreq/rdata/rpar/rack token channel, err1/err0/reack error channel,
//   out_valid/out_data/out_err/out_ready consumer side.
module resilient_rx_endpoint
    import resilient_pkg::*;
#(
    parameter int W           = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter bit DROP_ERR    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    resilient_rx_endpoint_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic         rreq_s;
    logic         reack_s;
    logic [1:0]   state;
    logic         req_ref;
    logic [W-1:0] tok_data;
    logic         tok_err;
    logic         seen_low;
    logic         rack_q;

    logic [W:0]   mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push_req;
    logic         do_push;
    logic         do_pop;
    logic         req_pend;
    logic [W:0]   head;

    sync_ff #(.STAGES(SYNC_STAGES)) u_rreq_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rreq),
        .q   (rreq_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_reack_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.reack),
        .q   (reack_s)
    );

    // A token is outstanding whenever the synchronised request phase differs from the
    // phase of the last token we captured.
    assign req_pend = rreq_s ^ req_ref;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            req_ref  <= 1'b0;
            tok_data <= '0;
            tok_err  <= 1'b0;
            seen_low <= 1'b0;
            rack_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Capture only when the FIFO can take the token; otherwise it waits
                    // un-acknowledged so upstream holds rdata stable.
                    if (req_pend && !fifo_full) begin
                        tok_data <= bus.rdata;
                        tok_err  <= ^{bus.rdata, bus.rpar};
                        req_ref  <= ~req_ref;
                        seen_low <= ~reack_s;
                        state    <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    // A reack that is already high on entry is stale: require it to be
                    // seen low before a rising reack can release the rails.
                    if (!reack_s) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        state <= ST_RTZ;
                    end
                end
                ST_RTZ: begin
                    if (!reack_s) begin
                        rack_q <= ~rack_q;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Rails decode straight from registered state, so they cannot move while in REPORT.
    assign bus.err1 = (state == ST_REPORT) &&  tok_err;
    assign bus.err0 = (state == ST_REPORT) && !tok_err;
    assign bus.rack = rack_q;

    assign push_req   = (state == ST_RTZ) && !reack_s && !(DROP_ERR && tok_err);
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Full is judged before this cycle's pop, so a simultaneous pop never frees room for a push.
    assign do_push    = push_req && !fifo_full;
    assign do_pop     = !fifo_empty && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= {tok_err, tok_data};
                wptr              <= wptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

    assign head          = mem[rptr[AW-1:0]];
    assign bus.out_valid = !fifo_empty;
    assign bus.out_err   = head[W];
    assign bus.out_data  = head[W-1:0];

endmodule

// File: tb/tb_resilient_rx_endpoint.sv
// tb/tb_resilient_rx_endpoint.sv - directed self-checking bench for resilient_rx_endpoint
module tb_resilient_rx_endpoint;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   drop_valid_cnt = 0;
    logic [8:0] popped [$];

    always #5 clk = ~clk;

    resilient_rx_endpoint_if #(.W(8)) bus ();
    resilient_rx_endpoint_if #(.W(8)) dbus ();

    resilient_rx_endpoint #(.W(8), .DEPTH(4), .SYNC_STAGES(2), .DROP_ERR(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    resilient_rx_endpoint #(.W(8), .DEPTH(4), .SYNC_STAGES(2), .DROP_ERR(1'b1)) dut_drop (
        .clk (clk),
        .rst (rst),
        .bus (dbus)
    );

    assign dbus.rreq      = bus.rreq;
    assign dbus.rdata     = bus.rdata;
    assign dbus.rpar      = bus.rpar;
    assign dbus.reack     = bus.reack;
    assign dbus.out_ready = 1'b1;

    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) popped.push_back({bus.out_err, bus.out_data});
        if (dbus.out_valid) drop_valid_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic p);
        bus.rdata = d;
        bus.rpar  = p;
        bus.rreq  = ~bus.rreq;
    endtask

    task automatic wait_rails(input int limit, output int cyc, output logic seen);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (bus.err1 || bus.err0) seen = 1'b1;
        end
    endtask

    task automatic finish_token(input string tag);
        logic r0;
        int   n;
        r0 = bus.rack;
        bus.reack = 1'b1;
        n = 0;
        while ((bus.err1 || bus.err0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_rtz"}, {31'd0, bus.err1 | bus.err0}, 32'd0);
        bus.reack = 1'b0;
        n = 0;
        while (bus.rack == r0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_rack"}, {31'd0, bus.rack}, {31'd0, ~r0});
    endtask

    task automatic send(input logic [7:0] d, input logic p, input logic exp_err, input string tag);
        int   cyc;
        logic seen;
        put(d, p);
        wait_rails(20, cyc, seen);
        check_val({tag, "_seen"}, {31'd0, seen}, 32'd1);
        check_val({tag, "_err1"}, {31'd0, bus.err1}, {31'd0, exp_err});
        check_val({tag, "_err0"}, {31'd0, bus.err0}, {31'd0, ~exp_err});
        finish_token(tag);
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int          cyc;
        logic        seen;
        logic        r1;
        int          dcnt0;
        int          base;
        logic [7:0]  bp_par;
        logic [7:0]  wrap_data [10];
        logic [9:0]  wrap_bad;

        bp_par    = 8'b0000_1011;
        wrap_data = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        wrap_bad  = 10'b10_0100_1001;

        rst = 1'b1;
        bus.rreq = 1'b0; bus.rdata = 8'h00; bus.rpar = 1'b0;
        bus.reack = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_rack", {31'd0, bus.rack}, 32'd0);
        check_val("rst_err1", {31'd0, bus.err1}, 32'd0);
        check_val("rst_err0", {31'd0, bus.err0}, 32'd0);
        check_val("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean token A5, even parity.
        put(8'hA5, 1'b0);
        wait_rails(20, cyc, seen);
        check_val("clean_latency", cyc, 32'd3);
        check_val("clean_err0", {31'd0, bus.err0}, 32'd1);
        check_val("clean_err1", {31'd0, bus.err1}, 32'd0);
        finish_token("clean");
        check_val("clean_rack", {31'd0, bus.rack}, 32'd1);
        check_val("clean_valid", {31'd0, bus.out_valid}, 32'd1);
        check_val("clean_data", {24'd0, bus.out_data}, 32'hA5);
        check_val("clean_oerr", {31'd0, bus.out_err}, 32'd0);
        pop_one();
        check_val("clean_empty", {31'd0, bus.out_valid}, 32'd0);

        // Bad parity token 01.
        dcnt0 = drop_valid_cnt;
        r1 = dbus.rack;
        send(8'h01, 1'b0, 1'b1, "bad");
        check_val("bad_rack", {31'd0, bus.rack}, 32'd0);
        check_val("bad_data", {24'd0, bus.out_data}, 32'h01);
        check_val("bad_oerr", {31'd0, bus.out_err}, 32'd1);
        check_val("drop_rack", {31'd0, dbus.rack}, {31'd0, ~r1});
        check_val("drop_novalid", drop_valid_cnt - dcnt0, 32'd0);
        pop_one();

        // Back-pressure: four tokens fill the FIFO, the fifth waits for a pop.
        for (int i = 1; i <= 4; i++) begin
            send(8'(i), bp_par[i-1], 1'b0, $sformatf("bp%0d", i));
        end
        check_val("bp_rack4", {31'd0, bus.rack}, 32'd0);
        put(8'd5, bp_par[4]);
        wait_rails(12, cyc, seen);
        check_val("bp_blocked", {31'd0, seen}, 32'd0);
        check_val("bp_norack", {31'd0, bus.rack}, 32'd0);
        base = popped.size();
        pop_one();
        wait_rails(20, cyc, seen);
        check_val("bp5_seen", {31'd0, seen}, 32'd1);
        finish_token("bp5");
        repeat (4) pop_one();
        check_val("bp_count", popped.size() - base, 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < popped.size())
                check_val($sformatf("bp_order%0d", i), {23'd0, popped[base+i]}, 32'(i + 1));
        end

        // Wrap: ten tokens streamed with the consumer always ready.
        bus.out_ready = 1'b1;
        base = popped.size();
        for (int i = 0; i < 10; i++) begin
            send(wrap_data[i], wrap_bad[i], wrap_bad[i], $sformatf("wrap%0d", i));
        end
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b0;
        check_val("wrap_count", popped.size() - base, 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < popped.size())
                check_val($sformatf("wrap_tok%0d", i), {23'd0, popped[base+i]},
                          {23'd0, wrap_bad[i], wrap_data[i]});
        end

        // Reset while reporting; rreq left at 1 so the token is re-captured.
        send(8'h77, 1'b0, 1'b0, "pre");
        put(8'h3C, 1'b0);
        wait_rails(20, cyc, seen);
        check_val("mid_err0", {31'd0, bus.err0}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mid_rst_err0", {31'd0, bus.err0}, 32'd0);
        check_val("mid_rst_rack", {31'd0, bus.rack}, 32'd0);
        check_val("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        wait_rails(20, cyc, seen);
        check_val("recap_seen", {31'd0, seen}, 32'd1);
        check_val("recap_err0", {31'd0, bus.err0}, 32'd1);
        finish_token("recap");
        check_val("recap_data", {24'd0, bus.out_data}, 32'h3C);
        repeat (10) @(negedge clk);
        check_val("recap_once_rack", {31'd0, bus.rack}, 32'd1);
        check_val("recap_once_rails", {31'd0, bus.err1 | bus.err0}, 32'd0);
        pop_one();
        check_val("recap_once_empty", {31'd0, bus.out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
